// File: rtl/m_sequence_dec_pkg.sv
// ============================================================================
// mseq_pkg : shared states, default constants and LFSR helpers (Rev 1.0)
// ============================================================================
`default_nettype none

package mseq_pkg;

  localparam int          MSEQ_LEN      = 6;
  localparam int          LFSR_MAX_W    = 32;
  localparam logic [5:0]  MSEQ_POLY_DEF = 6'b100111;
  localparam logic [5:0]  MSEQ_SEED_DEF = 6'b101010;

  typedef logic [LFSR_MAX_W-1:0] lfsr_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    TRACK   = 3'd2,
    SEARCH  = 3'd3,
    DONE    = 3'd4
  } mseq_state_e;

  // Right-shifting Fibonacci step; the caller keeps bits at and above w cleared.
  function automatic lfsr_t lfsr_step(input lfsr_t p, input lfsr_t poly,
                                      input int w = MSEQ_LEN);
    logic fb;
    fb = ^(poly & p);
    return (p >> 1) | (lfsr_t'(fb) << (w - 1));
  endfunction

  function automatic lfsr_t lfsr_adv(input lfsr_t p, input lfsr_t poly,
                                     input int n, input int w = MSEQ_LEN);
    lfsr_t r;
    r = p;
    for (int i = 0; i < LFSR_MAX_W; i++) begin
      if (i < n) r = lfsr_step(r, poly, w);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/m_sequence_dec.sv
// ============================================================================
// m_sequence_dec : recovers the shift code of one received M-sequence frame.
// Optional chip checking enabled by defining MSEQ_DEC_CHECK_EN.     (Rev 1.0)
// ============================================================================
`default_nettype none

module m_sequence_dec
  import mseq_pkg::*;
#(
  parameter int                N        = 63,
  parameter int                LENGTH   = $clog2(N),
  parameter logic [LENGTH-1:0] POLYNOME = MSEQ_POLY_DEF,
  parameter logic [LENGTH-1:0] SEED     = MSEQ_SEED_DEF,
  parameter int                THRESH   = 3
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              chip_i,
  input  logic              chip_valid_i,
  input  logic              sof_i,
  output logic              ready_o,
  output logic [LENGTH-1:0] code_o,
  output logic              code_valid_o,
  output logic [LENGTH-1:0] err_cnt_o,
  output logic              match_o,
  output logic              zero_err_o
);

  localparam int                CNT_W    = $clog2(N + 1);
  localparam logic [LENGTH-1:0] THRESH_L = LENGTH'(THRESH);

  function automatic logic [LENGTH-1:0] step_l(input logic [LENGTH-1:0] p);
    return LENGTH'(lfsr_step(lfsr_t'(p), lfsr_t'(POLYNOME), LENGTH));
  endfunction

  mseq_state_e       state_q, state_d;
  logic [LENGTH-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LENGTH-1:0] ref_q, ref_d;
  logic [LENGTH-1:0] k_q, k_d;
  logic [LENGTH-1:0] code_q, code_d;
  logic [LENGTH-1:0] err_out_q, err_out_d;
  logic              match_q, match_d;
  logic              zero_q, zero_d;
  logic [LENGTH-1:0] w_shift;
  logic [LENGTH-1:0] w_err;
  logic              w_zero_phase;

`ifdef MSEQ_DEC_CHECK_EN
  logic [LENGTH-1:0] local_q, local_d;
  logic [LENGTH-1:0] err_q, err_d;
  assign w_err = err_q;
`else
  assign w_err = '0;
`endif

  // Chip k lands in phase[k] once LENGTH chips have been shifted in.
  assign w_shift      = {chip_i, phase_q[LENGTH-1:1]};
  assign w_zero_phase = (phase_q == '0);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    ref_d     = ref_q;
    k_d       = k_q;
    code_d    = code_q;
    err_out_d = err_out_q;
    match_d   = match_q;
    zero_d    = zero_q;
`ifdef MSEQ_DEC_CHECK_EN
    local_d   = local_q;
    err_d     = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (chip_valid_i && sof_i) begin
          phase_d = w_shift;
          cnt_d   = CNT_W'(1);
          state_d = CAPTURE;
        end
      end

      CAPTURE, TRACK: begin
        if (chip_valid_i) begin
          if (sof_i) begin
            phase_d = w_shift;
            cnt_d   = CNT_W'(1);
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == CAPTURE) begin
              phase_d = w_shift;
              if (cnt_q == CNT_W'(LENGTH - 1)) begin
                state_d = TRACK;
`ifdef MSEQ_DEC_CHECK_EN
                local_d = LENGTH'(lfsr_adv(lfsr_t'(w_shift), lfsr_t'(POLYNOME),
                                           LENGTH, LENGTH));
                err_d   = '0;
`endif
              end
            end else begin
`ifdef MSEQ_DEC_CHECK_EN
              if ((chip_i != local_q[0]) && (err_q != '1))
                err_d = err_q + LENGTH'(1);
              local_d = step_l(local_q);
`endif
              if (cnt_q == CNT_W'(N - 1)) begin
                state_d = SEARCH;
                ref_d   = SEED;
                k_d     = '0;
              end
            end
          end
        end
      end

      SEARCH: begin
        if (w_zero_phase || (ref_q == phase_q)) begin
          state_d   = DONE;
          code_d    = w_zero_phase ? '0 : k_q;
          zero_d    = w_zero_phase;
          err_out_d = w_err;
          match_d   = (w_err <= THRESH_L) & ~w_zero_phase;
        end else begin
          ref_d = step_l(ref_q);
          k_d   = k_q + LENGTH'(1);
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (!rstn) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      cnt_q     <= '0;
      ref_q     <= '0;
      k_q       <= '0;
      code_q    <= '0;
      err_out_q <= '0;
      match_q   <= 1'b0;
      zero_q    <= 1'b0;
`ifdef MSEQ_DEC_CHECK_EN
      local_q   <= '0;
      err_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      ref_q     <= ref_d;
      k_q       <= k_d;
      code_q    <= code_d;
      err_out_q <= err_out_d;
      match_q   <= match_d;
      zero_q    <= zero_d;
`ifdef MSEQ_DEC_CHECK_EN
      local_q   <= local_d;
      err_q     <= err_d;
`endif
    end
  end

  assign ready_o      = (state_q == IDLE) || (state_q == CAPTURE) || (state_q == TRACK);
  assign code_valid_o = (state_q == DONE);
  assign code_o       = code_q;
  assign err_cnt_o    = err_out_q;
  assign match_o      = match_q;
  assign zero_err_o   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_m_sequence_dec.sv
// ============================================================================
// tb_m_sequence_dec : directed self-checking bench for m_sequence_dec (Rev 1.0)
// ============================================================================
`default_nettype none

module tb_m_sequence_dec;

  localparam logic [5:0] POLY = 6'b100111;
  localparam logic [5:0] SEED = 6'b101010;

  logic       clkin = 1'b0;
  logic       rstn = 1'b0;
  logic       chip_i = 1'b0;
  logic       chip_valid_i = 1'b0;
  logic       sof_i = 1'b0;
  logic       ready_o;
  logic [5:0] code_o;
  logic       code_valid_o;
  logic [5:0] err_cnt_o;
  logic       match_o;
  logic       zero_err_o;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;
  int lat;
  logic rdy1;

  m_sequence_dec dut (
    .clkin        (clkin),
    .rstn         (rstn),
    .chip_i       (chip_i),
    .chip_valid_i (chip_valid_i),
    .sof_i        (sof_i),
    .ready_o      (ready_o),
    .code_o       (code_o),
    .code_valid_o (code_valid_o),
    .err_cnt_o    (err_cnt_o),
    .match_o      (match_o),
    .zero_err_o   (zero_err_o)
  );

  always #5 clkin = ~clkin;

  always @(negedge clkin) if (code_valid_o === 1'b1) pulses++;

  function automatic logic [5:0] tb_step(input logic [5:0] p);
    return {p[5] ^ p[2] ^ p[1] ^ p[0], p[5:1]};
  endfunction

  function automatic logic [5:0] phase_of(input int code);
    logic [5:0] p;
    p = SEED;
    for (int i = 0; i < code; i++) p = tb_step(p);
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [5:0] ph, input logic [63:0] inv, input int gap, input int n);
    logic [5:0] p;
    p = ph;
    for (int i = 0; i < n; i++) begin
      chip_i       = p[0] ^ inv[i];
      sof_i        = (i == 0);
      chip_valid_i = 1'b1;
      @(posedge clkin); #1;
      chip_valid_i = 1'b0;
      sof_i        = 1'b0;
      if (i != n - 1) repeat (gap - 1) begin @(posedge clkin); #1; end
      p = tb_step(p);
    end
  endtask

  // lat counts cycles after the last chip's cycle; noise drives sof chips into SEARCH.
  task automatic wait_done(input int noise, output int l, output logic r1);
    l  = 1;
    r1 = ready_o;
    while (code_valid_o !== 1'b1 && l < 200) begin
      if (l <= noise) begin
        chip_valid_i = 1'b1;
        sof_i        = 1'b1;
        chip_i       = 1'($urandom_range(0, 1));
      end else begin
        chip_valid_i = 1'b0;
        sof_i        = 1'b0;
      end
      @(posedge clkin); #1;
      l++;
    end
    chip_valid_i = 1'b0;
    sof_i        = 1'b0;
  endtask

  initial begin
    // Reset state
    rstn = 1'b0;
    repeat (3) begin @(posedge clkin); #1; end
    check("rst_ready", ready_o, 1);
    check("rst_code", code_o, 0);
    check("rst_cv", code_valid_o, 0);
    check("rst_err", err_cnt_o, 0);
    check("rst_match", match_o, 0);
    check("rst_zero", zero_err_o, 0);
    rstn = 1'b1;
    @(posedge clkin); #1;

    // Code 5, chip every third cycle
    check("c5_phase_ready", ready_o, 1);
    send(phase_of(5), 64'd0, 3, 63);
    wait_done(0, lat, rdy1);
    check("c5_lat", lat, 7);
    check("c5_code", code_o, 5);
    check("c5_err", err_cnt_o, 0);
    check("c5_match", match_o, 1);
    check("c5_zero", zero_err_o, 0);
    @(posedge clkin); #1;
    check("c5_pulse_end", code_valid_o, 0);
    check("c5_ready_back", ready_o, 1);

    // Code 62: longest search, single pulse, outputs hold
    p0 = pulses;
    send(phase_of(62), 64'd0, 1, 63);
    wait_done(0, lat, rdy1);
    check("c62_search_ready", rdy1, 0);
    check("c62_lat", lat, 64);
    check("c62_code", code_o, 62);
    @(posedge clkin); #1;
    @(posedge clkin); #1;
    check("c62_pulses", pulses - p0, 1);
    check("c62_hold", code_o, 62);

    // Code 0
    send(phase_of(0), 64'd0, 1, 63);
    wait_done(0, lat, rdy1);
    check("c0_lat", lat, 2);
    check("c0_code", code_o, 0);
    check("c0_match", match_o, 1);
    @(posedge clkin); #1;

    // Code 20 with three inverted chips
    send(phase_of(20), (64'd1 << 10) | (64'd1 << 30) | (64'd1 << 50), 1, 63);
    wait_done(0, lat, rdy1);
    check("c20e3_code", code_o, 20);
`ifdef MSEQ_DEC_CHECK_EN
    check("c20e3_err", err_cnt_o, 3);
`else
    check("c20e3_err", err_cnt_o, 0);
`endif
    check("c20e3_match", match_o, 1);
    @(posedge clkin); #1;

    // Code 20 with four inverted chips
    send(phase_of(20), (64'd1 << 10) | (64'd1 << 20) | (64'd1 << 30) | (64'd1 << 40), 1, 63);
    wait_done(0, lat, rdy1);
    check("c20e4_code", code_o, 20);
`ifdef MSEQ_DEC_CHECK_EN
    check("c20e4_err", err_cnt_o, 4);
    check("c20e4_match", match_o, 0);
`else
    check("c20e4_err", err_cnt_o, 0);
    check("c20e4_match", match_o, 1);
`endif
    @(posedge clkin); #1;

    // All-zero frame
    send(6'd0, 64'd0, 1, 63);
    wait_done(0, lat, rdy1);
    check("zero_lat", lat, 2);
    check("zero_flag", zero_err_o, 1);
    check("zero_match", match_o, 0);
    check("zero_code", code_o, 0);
    @(posedge clkin); #1;

    // Abort code 7 at chip 40 with a fresh code-33 frame
    p0 = pulses;
    send(phase_of(7), 64'd0, 1, 40);
    send(phase_of(33), 64'd0, 1, 63);
    wait_done(0, lat, rdy1);
    check("abort_lat", lat, 35);
    check("abort_code", code_o, 33);
    check("abort_zero", zero_err_o, 0);
    check("abort_match", match_o, 1);
    @(posedge clkin); #1;
    @(posedge clkin); #1;
    check("abort_pulses", pulses - p0, 1);

    // Reset mid-TRACK
    send(phase_of(9), 64'd0, 1, 20);
    rstn = 1'b0;
    @(posedge clkin); #1;
    rstn = 1'b1;
    check("mrst_ready", ready_o, 1);
    check("mrst_code", code_o, 0);
    check("mrst_cv", code_valid_o, 0);
    check("mrst_match", match_o, 0);
    check("mrst_zero", zero_err_o, 0);
    check("mrst_err", err_cnt_o, 0);

    // Clean code 9 with chips thrown at the decoder during SEARCH
    p0 = pulses;
    send(phase_of(9), 64'd0, 1, 63);
    wait_done(5, lat, rdy1);
    check("c9_lat", lat, 11);
    check("c9_code", code_o, 9);
    check("c9_match", match_o, 1);
    @(posedge clkin); #1;
    @(posedge clkin); #1;
    check("c9_pulses", pulses - p0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
